// File: rtl/alu_op_sequencer_if.sv
// Command, ALU-side and response signals of alu_op_sequencer, bundled as one interface.
// The rsp_zero flag exists only when ALU_SEQ_ZFLAG_EN is defined.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 8
);
  // Handshakes (cmd_*, rsp_*): a transfer happens on a rising clk edge where
  // valid && ready; once raised, the sender holds valid and its payload until that edge.
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [1:0]       cmd_s1;
  logic [2:0]       cmd_s2;
  logic [3:0]       cmd_s3;
  logic             cmd_use_acc;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_s1;
  logic [2:0]       alu_s2;
  logic [3:0]       alu_s3;
  logic [WIDTH-1:0] alu_o;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
`ifdef ALU_SEQ_ZFLAG_EN
  logic             rsp_zero;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_s1, cmd_s2, cmd_s3, cmd_use_acc, alu_o, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_s1, alu_s2, alu_s3, rsp_valid, rsp_data, rsp_zero
  );
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_s1, cmd_s2, cmd_s3, cmd_use_acc, alu_o, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_s1, alu_s2, alu_s3, rsp_valid, rsp_data, rsp_zero
  );
`else
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_s1, cmd_s2, cmd_s3, cmd_use_acc, alu_o, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_s1, alu_s2, alu_s3, rsp_valid, rsp_data
  );
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_s1, cmd_s2, cmd_s3, cmd_use_acc, alu_o, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_s1, alu_s2, alu_s3, rsp_valid, rsp_data
  );
`endif
endinterface

// File: rtl/alu_op_sequencer.sv
// Command sequencer for the 8-bit ALU: registers a command onto the ALU inputs, waits
// SETTLE_CYCLES (1..15), captures the result into rsp_data/acc. Option: ALU_SEQ_ZFLAG_EN.
module alu_op_sequencer #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_op_sequencer_if.slave    bus,
  output logic                 busy,
  output logic [1:0]           dbg_state
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t           state;
  logic [3:0]       settle_cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [1:0]       alu_s1_q;
  logic [2:0]       alu_s2_q;
  logic [3:0]       alu_s3_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q;
`ifdef ALU_SEQ_ZFLAG_EN
  logic             rsp_zero_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      settle_cnt  <= 4'd0;
      acc         <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_s1_q    <= 2'd0;
      alu_s2_q    <= 3'd0;
      alu_s3_q    <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef ALU_SEQ_ZFLAG_EN
      rsp_zero_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            // acc here is the previous result; capture never coincides with accept
            alu_a_q    <= bus.cmd_use_acc ? acc : bus.cmd_a;
            alu_b_q    <= bus.cmd_b;
            alu_s1_q   <= bus.cmd_s1;
            alu_s2_q   <= bus.cmd_s2;
            alu_s3_q   <= bus.cmd_s3;
            settle_cnt <= 4'(SETTLE_CYCLES - 1);
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
          end else begin
            rsp_data_q  <= bus.alu_o;
            acc         <= bus.alu_o;
            rsp_valid_q <= 1'b1;
`ifdef ALU_SEQ_ZFLAG_EN
            rsp_zero_q  <= (bus.alu_o == '0);
`endif
            state       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // cmd_ready depends on state only, so no path exists from rsp_ready to cmd_ready
  assign bus.cmd_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign dbg_state     = state;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_s1    = alu_s1_q;
  assign bus.alu_s2    = alu_s2_q;
  assign bus.alu_s3    = alu_s3_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
`ifdef ALU_SEQ_ZFLAG_EN
  assign bus.rsp_zero  = rsp_zero_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: adder ALU stub, one instance with SETTLE_CYCLES=1 and one with 3.
// Define ALU_SEQ_ZFLAG_EN to also exercise rsp_zero.
module tb_alu_op_sequencer;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  logic busy0, busy1;
  logic [1:0] dbg0, dbg1;
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_acc;
  logic         ovr1_en;
  logic [W-1:0] ovr1_val;

  alu_op_sequencer_if #(.WIDTH(W)) bus0 ();
  alu_op_sequencer_if #(.WIDTH(W)) bus1 ();

  assign bus0.alu_o = bus0.alu_a + bus0.alu_b;
  assign bus1.alu_o = ovr1_en ? ovr1_val : (bus1.alu_a + bus1.alu_b);

  alu_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .busy(busy0), .dbg_state(dbg0)
  );
  alu_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .busy(busy1), .dbg_state(dbg1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver: called at a negedge; returns at the negedge after the accept edge
  task automatic send0(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] s1,
                       input logic [2:0] s2, input logic [3:0] s3, input logic use_acc);
    bit done = 0;
    logic [W-1:0] a_eff;
    bus0.cmd_a = a; bus0.cmd_b = b; bus0.cmd_s1 = s1; bus0.cmd_s2 = s2;
    bus0.cmd_s3 = s3; bus0.cmd_use_acc = use_acc; bus0.cmd_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (bus0.cmd_ready) done = 1;
      @(negedge clk);
    end
    bus0.cmd_valid = 1'b0;
    if (!done) begin
      check("send_timeout", 32'd0, 32'd1);
    end else begin
      a_eff = use_acc ? model_acc : a;
      model_acc = a_eff + b;
      exp_q.push_back(model_acc);
      check("alu_a", bus0.alu_a, a_eff);
      check("alu_b", bus0.alu_b, b);
      check("alu_s1", bus0.alu_s1, s1);
      check("alu_s2", bus0.alu_s2, s2);
      check("alu_s3", bus0.alu_s3, s3);
      check("busy_after_accept", busy0, 1'b1);
      check("cmd_ready_after_accept", bus0.cmd_ready, 1'b0);
    end
  endtask

  // scoreboard side: wait for the response, compare, complete the handshake
  task automatic recv0();
    bit done = 0;
    logic [W-1:0] exp;
    bus0.rsp_ready = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (bus0.rsp_valid) begin
        done = 1;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        check("rsp_data", bus0.rsp_data, exp);
`ifdef ALU_SEQ_ZFLAG_EN
        check("rsp_zero", bus0.rsp_zero, (exp == '0));
`endif
      end
      @(negedge clk);
    end
    if (!done) begin
      check("recv_timeout", 32'd0, 32'd1);
    end else begin
      check("rsp_valid_after_hs", bus0.rsp_valid, 1'b0);
      check("cmd_ready_after_hs", bus0.cmd_ready, 1'b1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    model_acc = '0;
    ovr1_en = 1'b0; ovr1_val = '0;
    bus0.cmd_valid = 0; bus0.cmd_a = 0; bus0.cmd_b = 0; bus0.cmd_s1 = 0; bus0.cmd_s2 = 0;
    bus0.cmd_s3 = 0; bus0.cmd_use_acc = 0; bus0.rsp_ready = 0;
    bus1.cmd_valid = 0; bus1.cmd_a = 0; bus1.cmd_b = 0; bus1.cmd_s1 = 0; bus1.cmd_s2 = 0;
    bus1.cmd_s3 = 0; bus1.cmd_use_acc = 0; bus1.rsp_ready = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset state
    check("rst_cmd_ready", bus0.cmd_ready, 1'b1);
    check("rst_busy", busy0, 1'b0);
    check("rst_dbg_state", dbg0, 2'd0);
    check("rst_rsp_valid", bus0.rsp_valid, 1'b0);
    check("rst_rsp_data", bus0.rsp_data, 8'h00);
    check("rst_alu_a", bus0.alu_a, 8'h00);
`ifdef ALU_SEQ_ZFLAG_EN
    check("rst_rsp_zero", bus0.rsp_zero, 1'b0);
`endif

    // 1: single command, SETTLE_CYCLES=1 -> response one edge after accept
    bus0.rsp_ready = 1'b1;
    send0(8'h07, 8'h04, 2'd0, 3'b001, 4'd0, 1'b0);
    check("s1_dbg_settle", dbg0, 2'd1);
    check("s1_rsp_valid_not_yet", bus0.rsp_valid, 1'b0);
    @(negedge clk);
    check("s1_rsp_valid_rise", bus0.rsp_valid, 1'b1);
    check("s1_dbg_resp", dbg0, 2'd2);
    recv0();

    // 2: chain on the accumulator
    send0(8'h07, 8'h04, 2'd1, 3'd2, 4'd3, 1'b0);
    recv0();
    send0(8'hAA, 8'h01, 2'd2, 3'd5, 4'd9, 1'b1);
    recv0();

    // 3: backpressure with a competing command held on cmd_valid
    bus0.rsp_ready = 1'b0;
    send0(8'h07, 8'h04, 2'd3, 3'd7, 4'd15, 1'b0);
    while (!bus0.rsp_valid && total_cnt < 1000) @(negedge clk);
    bus0.cmd_a = 8'h20; bus0.cmd_b = 8'h03; bus0.cmd_use_acc = 1'b0; bus0.cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_cmd_ready", bus0.cmd_ready, 1'b0);
      check("bp_rsp_valid", bus0.rsp_valid, 1'b1);
      check("bp_rsp_data", bus0.rsp_data, exp_q[0]);
      check("bp_alu_a", bus0.alu_a, 8'h07);
      bus0.cmd_a = 8'(8'h20 + i);
      @(negedge clk);
    end
    bus0.cmd_a = 8'h20;
    bus0.rsp_ready = 1'b1;
    check("bp_release_data", bus0.rsp_data, exp_q.pop_front());
    @(negedge clk);
    check("bp_hs_rsp_valid", bus0.rsp_valid, 1'b0);
    check("bp_hs_cmd_ready", bus0.cmd_ready, 1'b1);
    check("bp_no_second_accept", bus0.alu_a, 8'h07);
    @(negedge clk);
    bus0.cmd_valid = 1'b0;
    model_acc = 8'h23;
    exp_q.push_back(model_acc);
    check("bp_second_accept_a", bus0.alu_a, 8'h20);
    check("bp_second_busy", busy0, 1'b1);
    recv0();

    // 4: SETTLE_CYCLES=3 on the second instance; stub output changes late in settle
    bus1.cmd_a = 8'h10; bus1.cmd_b = 8'h20; bus1.cmd_valid = 1'b1;
    check("s4_cmd_ready", bus1.cmd_ready, 1'b1);
    @(negedge clk);
    bus1.cmd_valid = 1'b0;
    check("s4_alu_a", bus1.alu_a, 8'h10);
    check("s4_valid_n1", bus1.rsp_valid, 1'b0);
    @(negedge clk);
    check("s4_valid_n2", bus1.rsp_valid, 1'b0);
    @(negedge clk);
    check("s4_valid_n3", bus1.rsp_valid, 1'b0);
    ovr1_val = 8'h55; ovr1_en = 1'b1;
    @(negedge clk);
    check("s4_valid_rise", bus1.rsp_valid, 1'b1);
    check("s4_rsp_data", bus1.rsp_data, 8'h55);
    bus1.rsp_ready = 1'b1;
    @(negedge clk);
    check("s4_hs_valid", bus1.rsp_valid, 1'b0);
    check("s4_hs_ready", bus1.cmd_ready, 1'b1);
    ovr1_en = 1'b0; bus1.rsp_ready = 1'b0;

    // 5: reset in SETTLE drops the command and clears acc
    send0(8'h40, 8'h01, 2'd1, 3'd1, 4'd1, 1'b0);
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    model_acc = '0;
    check("s5_rst_busy", busy0, 1'b0);
    check("s5_rst_alu_a", bus0.alu_a, 8'h00);
    check("s5_rst_alu_s2", bus0.alu_s2, 3'd0);
    check("s5_rst_rsp_valid", bus0.rsp_valid, 1'b0);
    check("s5_rst_rsp_data", bus0.rsp_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("s5_no_rsp", bus0.rsp_valid, 1'b0);
    send0(8'h99, 8'h04, 2'd0, 3'd0, 4'd0, 1'b1);
    recv0();

`ifdef ALU_SEQ_ZFLAG_EN
    // 6: zero flag follows the captured result
    send0(8'hFF, 8'h01, 2'd0, 3'd0, 4'd0, 1'b0);
    recv0();
    send0(8'h01, 8'h01, 2'd0, 3'd0, 4'd0, 1'b0);
    recv0();
`endif

    // a few random single commands
    for (int i = 0; i < 6; i++) begin
      send0(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      recv0();
    end

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Upstream command stage for the 8-bit ALU. It accepts one ALU command per valid/ready handshake and registers the operands and select fields onto the ALU inputs. After a programmable settle time it captures the ALU combinational result, then presents that result downstream on a valid/ready handshake. It also keeps an accumulator, so a command can chain on the previous result.

Parameters:
WIDTH, 8, operand/result width; must match the ALU datapath.
SETTLE_CYCLES, 1, clock cycles alu_o is allowed to settle before capture; legal range 1..15; 0 is illegal.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_a  input  WIDTH  operand A
cmd_b  input  WIDTH  operand B
cmd_s1  input  2  ALU S1 select, passed verbatim
cmd_s2  input  3  ALU S2 select, passed verbatim
cmd_s3  input  4  ALU S3 select, passed verbatim
cmd_use_acc  input  1  1: operand A is taken from the accumulator, and cmd_a is ignored
alu_a  output  WIDTH  registered to ALU A
alu_b  output  WIDTH  registered to ALU B
alu_s1  output  2  registered to ALU S1
alu_s2  output  3  registered to ALU S2
alu_s3  output  4  registered to ALU S3
alu_o  input  WIDTH  ALU result (combinational)
rsp_valid  output  1  result available
rsp_ready  input  1  downstream accepts result
rsp_data  output  WIDTH  captured result
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, takes effect immediately): state IDLE; alu_a, alu_b, alu_s1, alu_s2, alu_s3, rsp_data and acc = 0; rsp_valid = 0; busy = 0; settle counter = 0. Reset during any state drops the in-flight command; no response is produced for it.
- States: IDLE, SETTLE, RESP.
- IDLE:
  - cmd_ready = 1.
  - Accept on cmd_valid && cmd_ready at edge N.
  - At edge N: alu_a <= cmd_use_acc ? acc : cmd_a; alu_b/alu_s1/alu_s2/alu_s3 <= cmd fields; counter <= SETTLE_CYCLES-1; go to SETTLE.
- SETTLE:
  - cmd_ready = 0.
  - Each edge with counter != 0 decrements the counter.
  - At the edge where counter == 0 (edge N+SETTLE_CYCLES): rsp_data <= alu_o; acc <= alu_o; rsp_valid <= 1; go to RESP.
- RESP:
  - cmd_ready = 0.
  - rsp_data and rsp_valid are held stable until rsp_valid && rsp_ready at some edge; at that edge rsp_valid <= 0 and state goes to IDLE.
  - rsp_ready held high gives a minimum of SETTLE_CYCLES+2 cycles per command.
- cmd_ready is a pure decode of state == IDLE, with no combinational path from rsp_ready. A response handshake and a new command acceptance never occur on the same edge.
- alu_* outputs change only at an accept edge or at reset; they hold their last values through RESP and IDLE.
- acc changes only at capture or reset. With cmd_use_acc = 1, alu_a takes the acc value in effect at the accept edge, i.e. the previous result.
- cmd_valid while cmd_ready = 0 is ignored; command fields may change freely during that time.
- rsp_ready while rsp_valid = 0 is ignored.
- Results are WIDTH bits; the sequencer applies no extension or truncation.

Optional Feature:
ALU_SEQ_ZFLAG_EN.
- Defined: adds output rsp_zero (1 bit), registered at capture as (alu_o == 0), with the same timing and hold rules as rsp_data; reset value 0.
- Undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
For all scenarios the bench uses an ALU stub with alu_o = alu_a + alu_b, wrapping at 8 bits. SETTLE_CYCLES = 1 unless stated.
1. After reset, send cmd a=0x07, b=0x04, s1=0, s2=3'b001, s3=0, use_acc=0, with rsp_ready=1 -> alu_a=0x07, alu_s2=001 the cycle after accept; rsp_valid rises 1 edge later with rsp_data=0x0B; cmd_ready returns to 1 one edge after the response handshake.
2. Chain: cmd a=0x07, b=0x04, then cmd use_acc=1, b=0x01 -> second rsp_data=0x0C; alu_a=0x0B on the second command.
3. Backpressure: hold rsp_ready=0 for 5 cycles while cmd_valid=1 with new data -> cmd_ready stays 0, rsp_data stays 0x0B throughout, no second accept; release rsp_ready -> exactly one handshake, then the second command is accepted.
4. SETTLE_CYCLES=3: accept at edge N -> rsp_valid first high after edge N+3; the bench changes the stub output at N+2 to 0x55 -> rsp_data=0x55.
5. Assert rst_n low during SETTLE -> all outputs 0 immediately, no rsp_valid; the next command completes normally, with acc starting from 0 (use_acc=1, b=0x04 -> 0x04).
6. With ALU_SEQ_ZFLAG_EN: a=0xFF, b=0x01 -> rsp_data=0x00, rsp_zero=1; next a=0x01, b=0x01 -> rsp_zero=0.
